// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-hazard stall insertion plus interrupt entry / eret sequencing beside the ID stage
module hazard_stall_ctrl #(
    parameter int LOAD_USE_STALL = 1,
    parameter int LOAD_JR_STALL  = 2,
    parameter int CNT_W          = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs_id,
    input  logic [4:0] Rt_id,
    input  logic       uses_rt_id,
    input  logic       jr_id,
    input  logic       mtc0_id,
    input  logic       eret_id,
    input  logic       MemRead_ex,
    input  logic [4:0] Rd_ex,
    input  logic       MemRead_mem,
    input  logic [4:0] Rd_mem,
    input  logic       int_req,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IDEX_bubble,
    output logic       IFID_flush,
    output logic       epc_we,
    output logic [1:0] pc_src,
    output logic       int_masked
);
    typedef enum logic [1:0] {RUN, STALL, INT_FLUSH, INT_VEC} st_t;
    st_t st;
    logic [CNT_W-1:0] cnt;
    logic [4:0] src;
    logic jr_dep, lu_dep, take_int;
    logic [CNT_W:0] need;
    always_comb begin
        src = jr_id ? Rs_id : Rt_id;
        jr_dep = (jr_id | mtc0_id) && src != 5'd0;
        lu_dep = MemRead_ex && Rd_ex != 5'd0 && (Rd_ex == Rs_id || (uses_rt_id && Rd_ex == Rt_id));
        // jr/jalr and mtc0 consume their operand in ID, so a load still in MEM also hazards
        need = (jr_dep && MemRead_ex && Rd_ex == src)   ? (CNT_W+1)'(LOAD_JR_STALL) :
               (jr_dep && MemRead_mem && Rd_mem == src) ? (CNT_W+1)'(LOAD_JR_STALL - 1) :
               lu_dep                                   ? (CNT_W+1)'(LOAD_USE_STALL) : '0;
        take_int = int_req && !int_masked;
    end
    always_comb begin
        PCWrite = 1'b1;
        IFIDWrite = 1'b1;
        IDEX_bubble = 1'b0;
        IFID_flush = 1'b0;
        epc_we = 1'b0;
        pc_src = 2'd0;
        if (!rst) begin
            case (st)
                RUN: begin
                    if (take_int) begin
                        IFID_flush = 1'b1;
                        IDEX_bubble = 1'b1;
                        PCWrite = 1'b0;
                        epc_we = 1'b1;
                    end else if (need != '0) begin
                        PCWrite = 1'b0;
                        IFIDWrite = 1'b0;
                        IDEX_bubble = 1'b1;
                    end else if (eret_id) begin
                        pc_src = 2'd2;
                        IFID_flush = 1'b1;
                    end
                end
                STALL: begin
                    PCWrite = 1'b0;
                    IFIDWrite = 1'b0;
                    IDEX_bubble = 1'b1;
                end
                INT_FLUSH: begin
                    IFID_flush = 1'b1;
                    IDEX_bubble = 1'b1;
                    PCWrite = 1'b0;
                end
                INT_VEC: pc_src = 2'd1;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= RUN;
            cnt <= '0;
            int_masked <= 1'b0;
        end else begin
            case (st)
                RUN: begin
                    if (take_int) st <= INT_FLUSH;
                    else if (need != '0) begin
                        cnt <= CNT_W'(need - 1'b1);
                        st <= (need > 1) ? STALL : RUN;
                    end else if (eret_id) int_masked <= 1'b0;
                end
                STALL: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CNT_W'(1)) st <= RUN;
                end
                INT_FLUSH: st <= INT_VEC;
                INT_VEC: begin
                    int_masked <= 1'b1;
                    st <= RUN;
                end
                default: st <= RUN;
            endcase
        end
    end
endmodule
